// File: rtl/serial_lut_loader.sv
// Serial LUT-load transmitter: shifts a parallel table image out MSB first on sd/sclk/scs_n
// so a serial_load_lut receiver ends up holding exactly table_in.
module serial_lut_loader #(
  parameter  int IN_WIDTH   = 3,
  parameter  int OUT_WIDTH  = 3,
  parameter  int CLK_DIV    = 2,
  localparam int TABLE_BITS = (2 ** IN_WIDTH) * OUT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TABLE_BITS-1:0] table_in,
  output logic                  busy,
  output logic                  done,
  output logic                  sd,
  output logic                  sclk,
  output logic                  scs_n
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int CNT_W = $clog2(TABLE_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(TABLE_BITS);
  localparam logic [CNT_W-1:0] BIT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

  logic [1:0]            state;
  logic [DIV_W-1:0]      div_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [TABLE_BITS-1:0] shreg_p0;

  logic div_last;
  logic last_bit;
  logic accept;
  logic shift_en;

  // div_cnt holds the cycles remaining in the current phase, including this one
  assign div_last = (div_cnt == DIV_ONE);
  assign last_bit = (bit_cnt == BIT_ONE);
  assign accept   = (state == ST_IDLE) && start;
  assign shift_en = (state == ST_HIGH) && div_last && !last_bit;

  // Image register: data only, so it carries no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg_p0 <= table_in;
    end else if (shift_en) begin
      shreg_p0 <= shreg_p0 << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sd      <= 1'b0;
      sclk    <= 1'b0;
      scs_n   <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_LOW;
            busy    <= 1'b1;
            scs_n   <= 1'b0;
            sclk    <= 1'b0;
            sd      <= table_in[TABLE_BITS-1];
            div_cnt <= DIV_LOAD;
            bit_cnt <= BIT_LOAD;
          end
        end
        ST_LOW: begin
          if (div_last) begin
            sclk    <= 1'b1;
            state   <= ST_HIGH;
            div_cnt <= DIV_LOAD;
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end
        ST_HIGH: begin
          if (div_last) begin
            // sd moves only on the falling edge so it is stable across the next rise
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt - BIT_ONE;
            div_cnt <= DIV_LOAD;
            if (!last_bit) begin
              sd    <= shreg_p0[TABLE_BITS-2];
              state <= ST_LOW;
            end else begin
              sd    <= 1'b0;
              state <= ST_TAIL;
            end
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end
        ST_TAIL: begin
          if (div_last) begin
            scs_n <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_lut_loader.sv
// Bench for serial_lut_loader: two instances (CLK_DIV=2 and CLK_DIV=1) driven by random
// images, each watched by a receiver model that rebuilds the table from sd on sclk rises.
module tb_serial_lut_loader;

  localparam int TB = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst     [2];
  logic          start   [2];
  logic [TB-1:0] tin     [2];
  logic [TB-1:0] exp_img [2];
  logic          busy    [2];
  logic          done    [2];
  logic          sd      [2];
  logic          sclk    [2];
  logic          scs_n   [2];

  int total = 0;
  int bad   = 0;

  serial_lut_loader #(.IN_WIDTH(3), .OUT_WIDTH(3), .CLK_DIV(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .table_in(tin[0]),
    .busy(busy[0]), .done(done[0]), .sd(sd[0]), .sclk(sclk[0]), .scs_n(scs_n[0])
  );

  serial_lut_loader #(.IN_WIDTH(3), .OUT_WIDTH(3), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .table_in(tin[1]),
    .busy(busy[1]), .done(done[1]), .sd(sd[1]), .sclk(sclk[1]), .scs_n(scs_n[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Receiver model plus framing rules, one per instance
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int DIV = (g == 0) ? 2 : 1;
    logic          p_sclk = 1'b0;
    logic          p_sd   = 1'b0;
    logic          p_csn  = 1'b1;
    logic          p_busy = 1'b0;
    logic [TB-1:0] rx     = '0;
    int            rises  = 0;
    int            stray  = 0;
    int            bcnt   = 0;
    int            done_cnt = 0;

    always @(negedge clk) begin
      if (sclk[g] === 1'b1 && p_sclk === 1'b1) begin
        check("sd_stable_hi", sd[g], p_sd);
        check("csn_stable_hi", scs_n[g], p_csn);
      end
      if (busy[g] === 1'b1 && p_busy !== 1'b1) begin
        rx    = '0;
        rises = 0;
        stray = 0;
        bcnt  = 0;
      end
      if (busy[g] === 1'b1) bcnt++;
      if (sclk[g] === 1'b1 && p_sclk !== 1'b1) begin
        if (scs_n[g] === 1'b0) begin
          rx = {rx[TB-2:0], sd[g]};
          rises++;
        end else begin
          stray++;
        end
      end
      if (done[g] === 1'b1) begin
        check("rx_image", rx, exp_img[g]);
        check("rise_count", rises, TB);
        check("stray_rises", stray, 0);
        check("busy_cycles", bcnt, 2 * DIV * TB + DIV);
        check("done_busy_low", busy[g], 1'b0);
        done_cnt++;
      end
      p_sclk = sclk[g];
      p_sd   = sd[g];
      p_csn  = scs_n[g];
      p_busy = busy[g];
    end
  end

  task automatic start_xfer(input int g, input logic [TB-1:0] img);
    @(negedge clk);
    start[g]   = 1'b1;
    tin[g]     = img;
    exp_img[g] = img;
    @(negedge clk);
    start[g] = 1'b0;
    tin[g]   = TB'($urandom);
  endtask

  // Called in cycle T1; returns in the cycle done is seen
  task automatic wait_done(input int g, input int exp_n, input string tag);
    int n;
    n = 1;
    while (done[g] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, n, exp_n);
  endtask

  task automatic check_idle(input int g, input string tag);
    check({tag, "_busy"}, busy[g], 1'b0);
    check({tag, "_done"}, done[g], 1'b0);
    check({tag, "_sd"}, sd[g], 1'b0);
    check({tag, "_sclk"}, sclk[g], 1'b0);
    check({tag, "_scs_n"}, scs_n[g], 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [TB-1:0] img1, img2;
    int n, k, last, dc;

    for (int i = 0; i < 2; i++) begin
      rst[i]     = 1'b1;
      start[i]   = 1'b0;
      tin[i]     = '0;
      exp_img[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Reference image at defaults
    start_xfer(0, 24'hA5C3F0);
    wait_done(0, 99, "t1_done_lat");

    // Re-pulsed start and wandering table_in during a transfer
    img1 = TB'($urandom);
    img2 = ~img1;
    @(negedge clk);
    start[0] = 1'b1; tin[0] = img1; exp_img[0] = img1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start[0] = (n == 10 || n == 50);
      tin[0]   = (n == 10 || n == 50) ? img2 : TB'($urandom);
    end while (done[0] !== 1'b1 && n < 400);
    start[0] = 1'b0;
    check("t3_done_lat", n, 99);

    // Reset mid-transfer
    start_xfer(0, TB'($urandom));
    repeat (39) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check_idle(0, "t4_after_rst");
    dc = g_mon[0].done_cnt;
    repeat (150) @(negedge clk);
    check("t4_no_done", g_mon[0].done_cnt, dc);
    start_xfer(0, 24'h123456);
    wait_done(0, 99, "t4_reload_lat");

    // rst and start together
    @(negedge clk);
    rst[0] = 1'b1; start[0] = 1'b1; tin[0] = TB'($urandom);
    @(negedge clk);
    rst[0] = 1'b0; start[0] = 1'b0;
    check("rst_wins_busy", busy[0], 1'b0);
    check("rst_wins_scs_n", scs_n[0], 1'b1);

    // start held high: back-to-back transfers
    img1 = TB'($urandom);
    @(negedge clk);
    start[0] = 1'b1; tin[0] = img1; exp_img[0] = img1;
    n = 0; k = 0; last = 0;
    while (k < 3 && n < 400) begin
      @(negedge clk);
      n++;
      if (done[0] === 1'b1) begin
        check("t5_done_spacing", n - last, 99);
        last = n;
        k++;
      end
    end
    start[0] = 1'b0;
    check("t5_done_count", k, 3);
    @(negedge clk);
    check("t5_stop_busy", busy[0], 1'b0);

    // Random images with random idle gaps
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      start_xfer(0, TB'($urandom));
      wait_done(0, 99, "rand_done_lat");
    end

    // CLK_DIV=1 instance
    start_xfer(1, 24'h000001);
    wait_done(1, 50, "t2_done_lat");
    start_xfer(1, TB'($urandom));
    wait_done(1, 50, "t2_rand_done_lat");

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
